id_stage: RTL

Decode stage of the pipelined RV32I core. It contains the IF/ID pipeline register, the instruction decoder and immediate extender, and the ID/EX pipeline register. It also drives the register-file read addresses and detects load-use hazards. It sits between fetch and execute: it feeds `a1`/`a2` to the register file, consumes `rd1`/`rd2`, and presents registered operands and control to the EX stage.

---
 rtl/riscv_pkg.sv | 48 ++++
 rtl/id_decoder.sv | 102 ++++++++++
 rtl/id_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, decoder enums and the control bundle.
// Used by the decode stage and its combinational decoder.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
  } imm_src_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101,
    ALU_LUI = 3'b110
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] result_src;
    alu_ctrl_t  alu_control;
  } ctrl_t;

  // All-zero control word: the pipeline bubble.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_decoder.sv
// Combinational RV32I decoder: main decoder, ALU decoder and immediate extender.
// Unsupported opcodes produce an all-zero (bubble) control word.
module id_decoder
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm_ext
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [1:0]         alu_op;
  imm_src_t           imm_src;
  logic signed [31:0] imm32;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    // NOTE: every output is given a default first so no path through the case can infer a latch.
    ctrl    = CTRL_BUBBLE;
    alu_op  = 2'b00;
    imm_src = IMM_I;
    case (opcode)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_S;
      end
      OP_R: begin
        ctrl.reg_write = 1'b1;
        alu_op         = 2'b10;
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        alu_op         = 2'b10;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        imm_src     = IMM_B;
        alu_op      = 2'b01;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_U;
        alu_op         = 2'b11;
      end
      default: ;
    endcase

    // Only R-type uses funct7[5] to select subtract; addi with bit 30 set is still an add.
    case (alu_op)
      2'b01: ctrl.alu_control = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  ctrl.alu_control = (opcode[5] && instr[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  ctrl.alu_control = ALU_SLT;
          3'b110:  ctrl.alu_control = ALU_OR;
          3'b111:  ctrl.alu_control = ALU_AND;
          default: ctrl.alu_control = ALU_ADD;
        endcase
      end
      2'b11:   ctrl.alu_control = ALU_LUI;
      default: ctrl.alu_control = ALU_ADD;
    endcase
  end

  always_comb begin
    case (imm_src)
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      default: imm32 = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  assign imm_ext = XLEN'(imm32);

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, decoder, ID/EX register and load-use detection.
// Define ID_WB_BYPASS_EN to forward the WB write port into the captured operands.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instr_f,
  input  logic [XLEN-1:0] pc_f,
  input  logic [XLEN-1:0] pcplus4_f,
  input  logic            pc_src_e,
  output logic [4:0]      a1,
  output logic [4:0]      a2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            we3_w,
  input  logic [4:0]      a3_w,
  input  logic [XLEN-1:0] wd3_w,
  output logic            stall_f,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pcplus4_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic            alu_src_e,
  output logic [1:0]      result_src_e,
  output logic [2:0]      alu_control_e
);

  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d, pcplus4_d;
  ctrl_t           ctrl_d, ctrl_e;
  logic [XLEN-1:0] imm_ext_d;
  logic [XLEN-1:0] op1_d, op2_d;
  logic            lwstall, bubble_e;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset || pc_src_e) begin
      instr_d   <= NOP_INSTR;
      pc_d      <= '0;
      pcplus4_d <= '0;
    end else if (!lwstall) begin
      instr_d   <= instr_f[31:0];
      pc_d      <= pc_f;
      pcplus4_d <= pcplus4_f;
    end
  end

  assign a1 = instr_d[19:15];
  assign a2 = instr_d[24:20];

  id_decoder #(.XLEN(XLEN)) u_decoder (
    .instr   (instr_d),
    .ctrl    (ctrl_d),
    .imm_ext (imm_ext_d)
  );

`ifdef ID_WB_BYPASS_EN
  // Covers a regfile that commits on the same rising edge that captures the operands.
  assign op1_d = (we3_w && (a3_w != 5'd0) && (a3_w == a1)) ? wd3_w : rd1;
  assign op2_d = (we3_w && (a3_w != 5'd0) && (a3_w == a2)) ? wd3_w : rd2;
`else
  logic unused_wb;
  assign unused_wb = ^{we3_w, a3_w, wd3_w};
  assign op1_d     = rd1;
  assign op2_d     = rd2;
`endif

  // rs2 is compared even for formats without rs2; a spare stall is harmless.
  assign lwstall  = (result_src_e == RES_MEM) && (rd_e != 5'd0) &&
                    ((rd_e == a1) || (rd_e == a2));
  assign stall_f  = lwstall;
  assign bubble_e = pc_src_e || lwstall;

  always_ff @(posedge clk) begin
    if (reset || bubble_e) begin
      ctrl_e    <= CTRL_BUBBLE;
      rd1_e     <= '0;
      rd2_e     <= '0;
      imm_ext_e <= '0;
      pc_e      <= '0;
      pcplus4_e <= '0;
      rs1_e     <= '0;
      rs2_e     <= '0;
      rd_e      <= '0;
    end else begin
      ctrl_e    <= ctrl_d;
      rd1_e     <= op1_d;
      rd2_e     <= op2_d;
      imm_ext_e <= imm_ext_d;
      pc_e      <= pc_d;
      pcplus4_e <= pcplus4_d;
      rs1_e     <= a1;
      rs2_e     <= a2;
      rd_e      <= instr_d[11:7];
    end
  end

  assign reg_write_e   = ctrl_e.reg_write;
  assign mem_write_e   = ctrl_e.mem_write;
  assign branch_e      = ctrl_e.branch;
  assign jump_e        = ctrl_e.jump;
  assign alu_src_e     = ctrl_e.alu_src;
  assign result_src_e  = ctrl_e.result_src;
  assign alu_control_e = ctrl_e.alu_control;

endmodule
